// File: rtl/ex_stage_if.sv
// Bundle between ID/EX, the execute stage and EX/MEM.
// Upstream drives the master side; ex_stage is the slave.
interface ex_stage_if;
  logic [4:0]  rs_ex;
  logic [4:0]  rt_ex;
  logic [4:0]  rd_ex;
  logic        regdst_ex;
  logic        memread_ex;
  logic        memtoreg_ex;
  logic [1:0]  aluop_ex;
  logic        memwrite_ex;
  logic        alusrc_ex;
  logic        regwrite_ex;
  logic [31:0] imm_ex;
  logic [31:0] read1_ex;
  logic [31:0] read2_ex;
  logic        memwb_regwrite;
  logic [4:0]  memwb_rd;
  logic [31:0] memwb_data;
  logic        stall;
  logic [31:0] alu_result_mem;
  logic [31:0] write_data_mem;
  logic [4:0]  dest_mem;
  logic        regwrite_mem;
  logic        memread_mem;
  logic        memtoreg_mem;
  logic        memwrite_mem;

  modport master (
    output rs_ex, rt_ex, rd_ex,
    output regdst_ex, memread_ex,
    output memtoreg_ex, aluop_ex,
    output memwrite_ex, alusrc_ex,
    output regwrite_ex, imm_ex,
    output read1_ex, read2_ex,
    output memwb_regwrite, memwb_rd,
    output memwb_data,
    input  stall, alu_result_mem,
    input  write_data_mem, dest_mem,
    input  regwrite_mem, memread_mem,
    input  memtoreg_mem, memwrite_mem
  );

  modport slave (
    input  rs_ex, rt_ex, rd_ex,
    input  regdst_ex, memread_ex,
    input  memtoreg_ex, aluop_ex,
    input  memwrite_ex, alusrc_ex,
    input  regwrite_ex, imm_ex,
    input  read1_ex, read2_ex,
    input  memwb_regwrite, memwb_rd,
    input  memwb_data,
    output stall, alu_result_mem,
    output write_data_mem, dest_mem,
    output regwrite_mem, memread_mem,
    output memtoreg_mem, memwrite_mem
  );
endinterface

// File: rtl/ex_stage.sv
// Execute stage: forwarding, ALU, iterative multiplier
// and the EX/MEM pipeline register.
module ex_stage #(
  parameter int MUL_CYCLES = 32
) (
  input  logic       clk,
  input  logic       reset,
  ex_stage_if.slave  bus
);

  localparam logic [4:0] LAST = 5'(MUL_CYCLES - 1);

  localparam logic [5:0] F_ADD = 6'h20;
  localparam logic [5:0] F_SUB = 6'h22;
  localparam logic [5:0] F_AND = 6'h24;
  localparam logic [5:0] F_OR  = 6'h25;
  localparam logic [5:0] F_SLT = 6'h2A;
  localparam logic [5:0] F_SLL = 6'h00;
  localparam logic [5:0] F_MUL = 6'h18;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DONE
  } state_t;

  state_t      state;
  logic [4:0]  count;
  logic [31:0] mcand;
  logic [31:0] mplier;
  logic [31:0] acc;
  logic [4:0]  mul_dest;
  logic [3:0]  mul_ctrl;

  logic [31:0] fwd_a;
  logic [31:0] fwd_b;
  logic [31:0] op_b;
  logic [31:0] alu_out;
  logic [4:0]  dest;
  logic [5:0]  funct;
  logic [4:0]  shamt;
  logic        mul_det;
  logic        hit_a_mem;
  logic        hit_b_mem;
  logic        hit_a_wb;
  logic        hit_b_wb;

  assign funct = bus.imm_ex[5:0];
  assign shamt = bus.imm_ex[10:6];
  assign dest  = bus.regdst_ex ? bus.rd_ex : bus.rt_ex;

  // Only a real mul (regwrite set) starts the multiplier;
  // a flushed bubble that still carries the funct does not.
  assign mul_det = (bus.aluop_ex == 2'b10) &&
                   (funct == F_MUL) &&
                   bus.regwrite_ex;

  assign hit_a_mem = bus.regwrite_mem &&
                     (bus.dest_mem != 5'd0) &&
                     (bus.dest_mem == bus.rs_ex);
  assign hit_b_mem = bus.regwrite_mem &&
                     (bus.dest_mem != 5'd0) &&
                     (bus.dest_mem == bus.rt_ex);
  assign hit_a_wb  = bus.memwb_regwrite &&
                     (bus.memwb_rd != 5'd0) &&
                     (bus.memwb_rd == bus.rs_ex);
  assign hit_b_wb  = bus.memwb_regwrite &&
                     (bus.memwb_rd != 5'd0) &&
                     (bus.memwb_rd == bus.rt_ex);

  // Forwarding muxes: the younger EX/MEM value beats MEM/WB.
  always_comb begin
    fwd_a = bus.read1_ex;
    fwd_b = bus.read2_ex;
    if (hit_a_mem)
      fwd_a = bus.alu_result_mem;
    else if (hit_a_wb)
      fwd_a = bus.memwb_data;
    if (hit_b_mem)
      fwd_b = bus.alu_result_mem;
    else if (hit_b_wb)
      fwd_b = bus.memwb_data;
  end

  assign op_b = bus.alusrc_ex ? bus.imm_ex : fwd_b;

  // Single-cycle ALU; mul funct yields 0 here because
  // the product comes from the iterative unit instead.
  always_comb begin
    alu_out = 32'd0;
    unique case (1'b1)
      (bus.aluop_ex == 2'b01):
        alu_out = fwd_a - op_b;
      (bus.aluop_ex == 2'b10): begin
        unique case (funct)
          F_ADD: alu_out = fwd_a + op_b;
          F_SUB: alu_out = fwd_a - op_b;
          F_AND: alu_out = fwd_a & op_b;
          F_OR:  alu_out = fwd_a | op_b;
          F_SLT: alu_out =
            ($signed(fwd_a) < $signed(op_b)) ?
            32'd1 : 32'd0;
          F_SLL: alu_out = fwd_b << shamt;
          default: alu_out = 32'd0;
        endcase
      end
      default:
        alu_out = fwd_a + op_b;
    endcase
  end

  // Hold the front of the pipe from mul detection
  // through the last multiply iteration.
  assign bus.stall = !reset &&
                     (((state == IDLE) && mul_det) ||
                      (state == MUL));

  // Multiplier FSM and EX/MEM pipeline register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state              <= IDLE;
      count              <= 5'd0;
      mcand              <= 32'd0;
      mplier             <= 32'd0;
      acc                <= 32'd0;
      mul_dest           <= 5'd0;
      mul_ctrl           <= 4'd0;
      bus.alu_result_mem <= 32'd0;
      bus.write_data_mem <= 32'd0;
      bus.dest_mem       <= 5'd0;
      bus.regwrite_mem   <= 1'b0;
      bus.memread_mem    <= 1'b0;
      bus.memtoreg_mem   <= 1'b0;
      bus.memwrite_mem   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (mul_det) begin
            mcand              <= fwd_a;
            mplier             <= fwd_b;
            acc                <= 32'd0;
            count              <= 5'd0;
            mul_dest           <= dest;
            mul_ctrl           <= {bus.regwrite_ex,
                                   bus.memread_ex,
                                   bus.memtoreg_ex,
                                   bus.memwrite_ex};
            state              <= MUL;
            bus.alu_result_mem <= 32'd0;
            bus.write_data_mem <= 32'd0;
            bus.dest_mem       <= 5'd0;
            bus.regwrite_mem   <= 1'b0;
            bus.memread_mem    <= 1'b0;
            bus.memtoreg_mem   <= 1'b0;
            bus.memwrite_mem   <= 1'b0;
          end else begin
            bus.alu_result_mem <= alu_out;
            bus.write_data_mem <= fwd_b;
            bus.dest_mem       <= dest;
            bus.regwrite_mem   <= bus.regwrite_ex;
            bus.memread_mem    <= bus.memread_ex;
            bus.memtoreg_mem   <= bus.memtoreg_ex;
            bus.memwrite_mem   <= bus.memwrite_ex;
          end
        end
        MUL: begin
          if (mplier[count])
            acc <= acc + (mcand << count);
          count <= count + 5'd1;
          if (count == LAST)
            state <= DONE;
          bus.alu_result_mem <= 32'd0;
          bus.write_data_mem <= 32'd0;
          bus.dest_mem       <= 5'd0;
          bus.regwrite_mem   <= 1'b0;
          bus.memread_mem    <= 1'b0;
          bus.memtoreg_mem   <= 1'b0;
          bus.memwrite_mem   <= 1'b0;
        end
        DONE: begin
          bus.alu_result_mem <= acc;
          bus.write_data_mem <= mplier;
          bus.dest_mem       <= mul_dest;
          bus.regwrite_mem   <= mul_ctrl[3];
          bus.memread_mem    <= mul_ctrl[2];
          bus.memtoreg_mem   <= mul_ctrl[1];
          bus.memwrite_mem   <= mul_ctrl[0];
          count              <= 5'd0;
          state              <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: vector table for the
// single-cycle path, hand sequences for mul and reset.
module tb_ex_stage;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  ex_stage_if bus ();

  ex_stage #(.MUL_CYCLES(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [4:0]  rs, rt, rd;
    logic        regdst, memread, memtoreg;
    logic [1:0]  aluop;
    logic        memwrite, alusrc, regwrite;
    logic [31:0] imm, r1, r2;
    logic        wb_rw;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic [31:0] e_res, e_wd;
    logic [4:0]  e_dest;
    logic [3:0]  e_ctrl;
  } vec_t;

  vec_t vec [17];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h",
               name, act, exp);
    end
  endtask

  task automatic bubble();
    bus.rs_ex = 0; bus.rt_ex = 0; bus.rd_ex = 0;
    bus.regdst_ex = 0; bus.memread_ex = 0;
    bus.memtoreg_ex = 0; bus.aluop_ex = 0;
    bus.memwrite_ex = 0; bus.alusrc_ex = 0;
    bus.regwrite_ex = 0; bus.imm_ex = 0;
    bus.read1_ex = 0; bus.read2_ex = 0;
    bus.memwb_regwrite = 0; bus.memwb_rd = 0;
    bus.memwb_data = 0;
  endtask

  task automatic drive(input vec_t v);
    bus.rs_ex = v.rs; bus.rt_ex = v.rt;
    bus.rd_ex = v.rd; bus.regdst_ex = v.regdst;
    bus.memread_ex = v.memread;
    bus.memtoreg_ex = v.memtoreg;
    bus.aluop_ex = v.aluop;
    bus.memwrite_ex = v.memwrite;
    bus.alusrc_ex = v.alusrc;
    bus.regwrite_ex = v.regwrite;
    bus.imm_ex = v.imm;
    bus.read1_ex = v.r1; bus.read2_ex = v.r2;
    bus.memwb_regwrite = v.wb_rw;
    bus.memwb_rd = v.wb_rd;
    bus.memwb_data = v.wb_data;
  endtask

  task automatic drive_mul(input logic [31:0] a,
                           input logic [31:0] b,
                           input logic [4:0] d);
    bubble();
    bus.rs_ex = 5'd1; bus.rt_ex = 5'd2;
    bus.rd_ex = d; bus.regdst_ex = 1'b1;
    bus.aluop_ex = 2'b10; bus.imm_ex = 32'h18;
    bus.regwrite_ex = 1'b1;
    bus.read1_ex = a; bus.read2_ex = b;
  endtask

  function automatic logic [3:0] ctrl_now();
    return {bus.regwrite_mem, bus.memread_mem,
            bus.memtoreg_mem, bus.memwrite_mem};
  endfunction

  // Leaves the mul inputs applied so a caller can
  // chain another mul straight after the result edge.
  task automatic run_mul(input logic [31:0] a,
                         input logic [31:0] b,
                         input logic [31:0] p,
                         input logic [4:0] d);
    int n = 0;
    int bad = 0;
    drive_mul(a, b, d);
    #1;
    while (bus.stall && n < 40) begin
      @(posedge clk); #1;
      n++;
      if (bus.alu_result_mem != 0 ||
          ctrl_now() != 4'd0 || bus.dest_mem != 0)
        bad++;
    end
    chk("mul_stall_cycles", n, 33);
    chk("mul_bubbles", bad, 0);
    @(posedge clk); #1;
    chk("mul_result", bus.alu_result_mem, p);
    chk("mul_dest", {27'd0, bus.dest_mem}, {27'd0, d});
    chk("mul_ctrl", {28'd0, ctrl_now()}, 32'h8);
    chk("mul_wdata", bus.write_data_mem, b);
  endtask

  initial begin
    vec[0]  = '{1,2,3, 1,0,0,2'b10,0,0,1,32'h20, 5,7,
                0,0,0, 12,7,3,4'b1000};
    vec[1]  = '{3,5,4, 1,0,0,2'b10,0,0,1,32'h22, 99,2,
                0,0,0, 10,2,4,4'b1000};
    vec[2]  = '{0,0,6, 1,0,0,2'b00,0,0,1,0, 1,1,
                0,0,0, 2,1,6,4'b1000};
    vec[3]  = '{3,5,7, 1,0,0,2'b10,0,0,1,32'h22, 99,2,
                1,3,12, 10,2,7,4'b1000};
    vec[4]  = '{7,0,8, 1,0,0,2'b10,0,0,1,32'h20, 99,3,
                1,7,50, 13,3,8,4'b1000};
    vec[5]  = '{1,2,0, 1,0,0,2'b00,0,0,1,0, 1,1,
                0,0,0, 2,1,0,4'b1000};
    vec[6]  = '{0,0,9, 1,0,0,2'b10,0,0,1,32'h20, 40,2,
                1,0,77, 42,2,9,4'b1000};
    vec[7]  = '{10,11,12, 0,1,1,2'b00,0,1,1,
                32'hFFFF_FFFC, 32'h100,32'h55,
                0,0,0, 32'hFC,32'h55,11,4'b1110};
    vec[8]  = '{13,14,12, 1,0,0,2'b10,0,0,1,32'h2A,
                32'hFFFF_FFFF,1, 0,0,0, 1,1,12,4'b1000};
    vec[9]  = '{0,16,15, 1,0,0,2'b10,0,0,1,32'h7C0, 0,1,
                0,0,0, 32'h8000_0000,1,15,4'b1000};
    vec[10] = '{17,18,0, 0,0,0,2'b00,1,1,0,8,
                32'h200,32'hDEAD, 0,0,0,
                32'h208,32'hDEAD,18,4'b0001};
    vec[11] = '{19,20,19, 1,0,0,2'b10,0,0,1,32'h3F, 3,4,
                0,0,0, 0,4,19,4'b1000};
    vec[12] = '{21,22,20, 1,0,0,2'b10,0,0,1,32'h24,
                32'hF0F0,32'hFF00, 0,0,0,
                32'hF000,32'hFF00,20,4'b1000};
    vec[13] = '{23,24,25, 1,0,0,2'b10,0,0,1,32'h25,
                32'hF0F0,32'h0F0F, 0,0,0,
                32'hFFFF,32'h0F0F,25,4'b1000};
    vec[14] = '{26,27,28, 1,0,0,2'b11,0,0,1,0,
                32'hFFFF_FFFF,2, 0,0,0, 1,2,28,4'b1000};
    vec[15] = '{29,30,31, 1,0,0,2'b01,0,0,1,0, 3,5,
                0,0,0, 32'hFFFF_FFFE,5,31,4'b1000};
    vec[16] = '{4,1,0, 0,0,0,2'b10,0,0,0,32'h18, 5,6,
                0,0,0, 0,6,1,4'b0000};

    bubble();
    bus.aluop_ex = 2'b10; bus.imm_ex = 32'h18;
    bus.regwrite_ex = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_stall", {31'd0, bus.stall}, 0);
    chk("rst_res", bus.alu_result_mem, 0);
    chk("rst_wd", bus.write_data_mem, 0);
    chk("rst_dest", {27'd0, bus.dest_mem}, 0);
    chk("rst_ctrl", {28'd0, ctrl_now()}, 0);
    bubble();
    reset = 1'b0;

    for (int i = 0; i < 17; i++) begin
      drive(vec[i]);
      #1;
      chk($sformatf("v%0d_stall", i),
          {31'd0, bus.stall}, 0);
      @(posedge clk); #1;
      chk($sformatf("v%0d_res", i),
          bus.alu_result_mem, vec[i].e_res);
      chk($sformatf("v%0d_wd", i),
          bus.write_data_mem, vec[i].e_wd);
      chk($sformatf("v%0d_dest", i),
          {27'd0, bus.dest_mem},
          {27'd0, vec[i].e_dest});
      chk($sformatf("v%0d_ctrl", i),
          {28'd0, ctrl_now()},
          {28'd0, vec[i].e_ctrl});
    end

    run_mul(32'h0001_0003, 32'h5, 32'h0005_000F, 5);
    run_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1, 6);
    run_mul(32'd7, 32'd6, 32'd42, 7);
    bubble();
    @(posedge clk); #1;
    chk("post_mul_bubble", {28'd0, ctrl_now()}, 0);

    begin
      int bad = 0;
      drive_mul(32'd3, 32'd3, 5'd9);
      @(posedge clk);
      repeat (10) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk); #1;
      chk("abort_stall", {31'd0, bus.stall}, 0);
      chk("abort_res", bus.alu_result_mem, 0);
      chk("abort_ctrl", {28'd0, ctrl_now()}, 0);
      chk("abort_dest", {27'd0, bus.dest_mem}, 0);
      reset = 1'b0;
      bubble();
      #1;
      chk("abort_stall_rel", {31'd0, bus.stall}, 0);
      for (int c = 0; c < 40; c++) begin
        @(posedge clk); #1;
        if (bus.stall || bus.regwrite_mem ||
            bus.alu_result_mem == 32'd9)
          bad++;
      end
      chk("abort_no_product", bad, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
